ext_r_fifo_ipa: RTL and testbench

//  Parametrised AXI read-data (R) channel FIFO for the external unit, successor to the 2-entry R buffer.

---
 rtl/ext_r_fifo_ipa.sv | 179 +++++++++++++++++
 tb/tb_ext_r_fifo_ipa.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_r_fifo_ipa.sv
// ext_r_fifo_ipa: AXI read-data (R) channel FIFO for the external unit.
//
// Buffers R beats between a slave-side producer and a master-side consumer. Depth is any integer
// >= 2. Reports the number of stored beats and the number of complete bursts (stored last beats).
// With STORE_FWD=1 beats are held back until a whole burst is present. When the FIFO is full,
// it forwards cut-through so that a burst longer than the FIFO cannot deadlock.
//
// Ports:
//   clk_i, rst_ni      clock (rising edge) and synchronous active-low reset
//   slave_*            upstream R channel (valid/ready handshake, payload in)
//   master_*           downstream R channel (valid/ready handshake, payload out)
//   level_o            beats currently stored
//   bursts_o           complete bursts (last beats) currently stored
module ext_r_fifo_ipa #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 6,
  parameter int unsigned DEPTH      = 4,
  parameter bit          STORE_FWD  = 1'b0,
  parameter int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  slave_valid_i,
  input  logic [DATA_WIDTH-1:0] slave_data_i,
  input  logic [1:0]            slave_resp_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic                  slave_last_i,
  output logic                  slave_ready_o,

  output logic                  master_valid_o,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [1:0]            master_resp_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic                  master_last_o,
  input  logic                  master_ready_i,

  output logic [CNT_WIDTH-1:0]  level_o,
  output logic [CNT_WIDTH-1:0]  bursts_o
);

  localparam int unsigned PtrWidth   = $clog2(DEPTH);
  localparam int unsigned EntryWidth = ID_WIDTH + USER_WIDTH + DATA_WIDTH + 2 + 1;

  localparam logic [PtrWidth-1:0]  PtrMax  = PtrWidth'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CntFull = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] CntOne  = CNT_WIDTH'(1);

  // Storage: entry layout is {id, user, data, resp, last}. Contents are not reset.
  logic [EntryWidth-1:0] r_mem [DEPTH];

  logic [PtrWidth-1:0]  r_wr_ptr;
  logic [PtrWidth-1:0]  r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_level;
  logic [CNT_WIDTH-1:0] r_bursts;

  logic [PtrWidth-1:0]  w_wr_ptr_nxt;
  logic [PtrWidth-1:0]  w_rd_ptr_nxt;
  logic [CNT_WIDTH-1:0] w_level_nxt;
  logic [CNT_WIDTH-1:0] w_bursts_nxt;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_release;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_push_last;
  logic                  w_pop_last;
  logic [EntryWidth-1:0] w_wr_entry;
  logic [EntryWidth-1:0] w_rd_entry;

  // ---------------------------------------------------------------------------------------------
  // Status and handshake
  // ---------------------------------------------------------------------------------------------
  assign w_full  = (r_level == CntFull);
  assign w_empty = (r_level == '0);

  // Store-and-forward waits for a stored last beat; when full it must forward anyway, otherwise a
  // burst longer than DEPTH could never complete.
  assign w_release = STORE_FWD ? ((r_bursts != '0) | w_full) : 1'b1;

  // Both handshake outputs depend on registered state only (no ready->ready or valid->valid path).
  assign slave_ready_o  = rst_ni & ~w_full;
  assign master_valid_o = rst_ni & ~w_empty & w_release;

  assign w_push      = slave_valid_i & slave_ready_o;
  assign w_pop       = master_valid_o & master_ready_i;
  assign w_push_last = w_push & slave_last_i;
  assign w_pop_last  = w_pop & master_last_o;

  assign level_o  = r_level;
  assign bursts_o = r_bursts;

  // ---------------------------------------------------------------------------------------------
  // Payload
  // ---------------------------------------------------------------------------------------------
  assign w_wr_entry = {slave_id_i, slave_user_i, slave_data_i, slave_resp_i, slave_last_i};
  assign w_rd_entry = r_mem[r_rd_ptr];

  assign {master_id_o, master_user_o, master_data_o, master_resp_o, master_last_o} = w_rd_entry;

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wr_entry;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  // Explicit wrap so that non-power-of-two depths work.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    if (w_push) begin
      w_wr_ptr_nxt = (r_wr_ptr == PtrMax) ? '0 : r_wr_ptr + PtrWidth'(1);
    end
  end

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_pop) begin
      w_rd_ptr_nxt = (r_rd_ptr == PtrMax) ? '0 : r_rd_ptr + PtrWidth'(1);
    end
  end

  always_comb begin
    w_level_nxt = r_level;
    unique case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + CntOne;
      2'b01:   w_level_nxt = r_level - CntOne;
      default: w_level_nxt = r_level;
    endcase
  end

  always_comb begin
    w_bursts_nxt = r_bursts;
    unique case ({w_push_last, w_pop_last})
      2'b10:   w_bursts_nxt = r_bursts + CntOne;
      2'b01:   w_bursts_nxt = r_bursts - CntOne;
      default: w_bursts_nxt = r_bursts;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // State registers (synchronous reset)
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_bursts <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_level  <= w_level_nxt;
      r_bursts <= w_bursts_nxt;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Protocol checks (simulation only)
  // ---------------------------------------------------------------------------------------------
`ifndef SYNTHESIS
  // A presented beat that is not taken must stay presented and unchanged.
  a_valid_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (master_valid_o && !master_ready_i) |=> (master_valid_o && $stable(w_rd_entry)));

  a_level_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_level <= CntFull));

  a_bursts_bound : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_bursts <= r_level));
`endif

endmodule

// File: tb/tb_ext_r_fifo_ipa.sv
// tb_ext_r_fifo_ipa: directed bench for ext_r_fifo_ipa.
//
// Three instances share clock and reset:
//   u0: cut-through, DEPTH=4
//   u1: store-and-forward, DEPTH=8
//   u2: store-and-forward, DEPTH=4 (full override with a 6-beat burst)
module tb_ext_r_fifo_ipa;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  // u0 signals
  logic        sv0, sl0, mr0, srdy0, mv0, ml0;
  logic [63:0] sd0, md0;
  logic [1:0]  sr0, mresp0;
  logic [5:0]  su0, mu0;
  logic [3:0]  si0, mi0;
  logic [2:0]  lvl0, bur0;

  // u1 signals
  logic        sv1, sl1, mr1, srdy1, mv1, ml1;
  logic [63:0] sd1, md1;
  logic [1:0]  sr1, mresp1;
  logic [5:0]  su1, mu1;
  logic [3:0]  si1, mi1;
  logic [3:0]  lvl1, bur1;

  // u2 signals
  logic        sv2, sl2, mr2, srdy2, mv2, ml2;
  logic [63:0] sd2, md2;
  logic [1:0]  sr2, mresp2;
  logic [5:0]  su2, mu2;
  logic [3:0]  si2, mi2;
  logic [2:0]  lvl2, bur2;

  ext_r_fifo_ipa #(.DEPTH(4), .STORE_FWD(1'b0)) u0 (
    .clk_i(clk), .rst_ni(rst_n),
    .slave_valid_i(sv0), .slave_data_i(sd0), .slave_resp_i(sr0), .slave_user_i(su0),
    .slave_id_i(si0), .slave_last_i(sl0), .slave_ready_o(srdy0),
    .master_valid_o(mv0), .master_data_o(md0), .master_resp_o(mresp0), .master_user_o(mu0),
    .master_id_o(mi0), .master_last_o(ml0), .master_ready_i(mr0),
    .level_o(lvl0), .bursts_o(bur0)
  );

  ext_r_fifo_ipa #(.DEPTH(8), .STORE_FWD(1'b1)) u1 (
    .clk_i(clk), .rst_ni(rst_n),
    .slave_valid_i(sv1), .slave_data_i(sd1), .slave_resp_i(sr1), .slave_user_i(su1),
    .slave_id_i(si1), .slave_last_i(sl1), .slave_ready_o(srdy1),
    .master_valid_o(mv1), .master_data_o(md1), .master_resp_o(mresp1), .master_user_o(mu1),
    .master_id_o(mi1), .master_last_o(ml1), .master_ready_i(mr1),
    .level_o(lvl1), .bursts_o(bur1)
  );

  ext_r_fifo_ipa #(.DEPTH(4), .STORE_FWD(1'b1)) u2 (
    .clk_i(clk), .rst_ni(rst_n),
    .slave_valid_i(sv2), .slave_data_i(sd2), .slave_resp_i(sr2), .slave_user_i(su2),
    .slave_id_i(si2), .slave_last_i(sl2), .slave_ready_o(srdy2),
    .master_valid_o(mv2), .master_data_o(md2), .master_resp_o(mresp2), .master_user_o(mu2),
    .master_id_o(mi2), .master_last_o(ml2), .master_ready_i(mr2),
    .level_o(lvl2), .bursts_o(bur2)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] rx[$];
  int          idx;
  logic        do_push, do_pop;

  initial begin
    {sv0, sl0, mr0, sd0, sr0, su0, si0} = '0;
    {sv1, sl1, mr1, sd1, sr1, su1, si1} = '0;
    {sv2, sl2, mr2, sd2, sr2, su2, si2} = '0;

    // ---- Reset held 3 cycles with upstream valid asserted ----
    rst_n = 1'b0;
    sv0 = 1'b1; sv1 = 1'b1; sv2 = 1'b1;
    repeat (3) tick();
    check("rst u0 slave_ready", srdy0, 0);
    check("rst u0 master_valid", mv0, 0);
    check("rst u1 slave_ready", srdy1, 0);
    check("rst u1 master_valid", mv1, 0);
    check("rst u2 slave_ready", srdy2, 0);
    check("rst u2 master_valid", mv2, 0);
    rst_n = 1'b1;
    sv0 = 1'b0; sv1 = 1'b0; sv2 = 1'b0;
    #1;
    check("post-rst u0 level", lvl0, 0);
    check("post-rst u0 bursts", bur0, 0);
    check("post-rst u0 slave_ready", srdy0, 1);
    check("post-rst u0 master_valid", mv0, 0);
    check("post-rst u1 level", lvl1, 0);
    check("post-rst u2 bursts", bur2, 0);

    // ---- u0 cut-through: one beat, 1-cycle latency ----
    sv0 = 1'b1; sd0 = 64'hA5; si0 = 4'd3; sl0 = 1'b1; sr0 = 2'b10; su0 = 6'h2A;
    tick();
    sv0 = 1'b0;
    check("ct valid", mv0, 1);
    check("ct data", md0, 64'hA5);
    check("ct id", mi0, 3);
    check("ct last", ml0, 1);
    check("ct resp", mresp0, 2'b10);
    check("ct user", mu0, 6'h2A);
    check("ct level", lvl0, 1);
    check("ct bursts", bur0, 1);
    mr0 = 1'b1;
    tick();
    mr0 = 1'b0;
    check("ct level after pop", lvl0, 0);
    check("ct bursts after pop", bur0, 0);
    check("ct valid after pop", mv0, 0);

    // ---- u0 fill and pointer wrap ----
    sr0 = 2'b00; su0 = '0; si0 = 4'd1;
    for (int i = 0; i < 4; i++) begin
      sv0 = 1'b1; sd0 = 64'h10 + 64'(i); sl0 = (i == 3);
      tick();
    end
    sv0 = 1'b0;
    check("fill slave_ready", srdy0, 0);
    check("fill level", lvl0, 4);
    check("fill bursts", bur0, 1);
    check("fill head data", md0, 64'h10);
    // Pop while full with a push offered: no bypass, push must be refused.
    sv0 = 1'b1; sd0 = 64'h14; sl0 = 1'b1; mr0 = 1'b1;
    tick();
    mr0 = 1'b0;
    check("full pop level", lvl0, 3);
    check("full pop ready back", srdy0, 1);
    check("full pop bursts", bur0, 1);
    tick();
    sv0 = 1'b0;
    check("wrap push level", lvl0, 4);
    check("wrap push bursts", bur0, 2);
    mr0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wrap drain data %0d", i), md0, 64'h11 + 64'(i));
      tick();
    end
    mr0 = 1'b0;
    check("wrap drained level", lvl0, 0);
    check("wrap drained bursts", bur0, 0);

    // ---- u0 simultaneous push and pop ----
    sv0 = 1'b1; sd0 = 64'h20; sl0 = 1'b0;
    tick();
    sd0 = 64'h21; sl0 = 1'b1;
    tick();
    check("simul pre level", lvl0, 2);
    check("simul pre bursts", bur0, 1);
    sd0 = 64'h22; sl0 = 1'b0; mr0 = 1'b1;   // pops 0x20 (last=0)
    tick();
    check("simul level", lvl0, 2);
    check("simul bursts", bur0, 1);
    sd0 = 64'h23; sl0 = 1'b1;               // pops 0x21 (last=1), pushes last=1
    tick();
    check("simul last level", lvl0, 2);
    check("simul last bursts", bur0, 1);
    sv0 = 1'b0;
    check("simul drain data 0", md0, 64'h22);
    tick();
    check("simul drain data 1", md0, 64'h23);
    tick();
    mr0 = 1'b0;
    check("simul end level", lvl0, 0);
    check("simul end bursts", bur0, 0);

    // ---- u1 store-and-forward, DEPTH=8 ----
    for (int i = 0; i < 3; i++) begin
      sv1 = 1'b1; sd1 = 64'h30 + 64'(i); sl1 = 1'b0;
      tick();
      check($sformatf("sf held valid %0d", i), mv1, 0);
    end
    check("sf held level", lvl1, 3);
    sd1 = 64'h33; sl1 = 1'b1;
    tick();
    sv1 = 1'b0;
    check("sf release valid", mv1, 1);
    check("sf release bursts", bur1, 1);
    check("sf release level", lvl1, 4);
    mr1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sf drain data %0d", i), md1, 64'h30 + 64'(i));
      tick();
    end
    mr1 = 1'b0;
    check("sf drained bursts", bur1, 0);
    check("sf drained valid", mv1, 0);

    // ---- u2 store-and-forward, 6-beat burst through DEPTH=4 ----
    for (int i = 0; i < 4; i++) begin
      sv2 = 1'b1; sd2 = 64'h40 + 64'(i); sl2 = 1'b0;
      tick();
    end
    sv2 = 1'b0;
    check("ovr level full", lvl2, 4);
    check("ovr valid at full", mv2, 1);
    check("ovr bursts", bur2, 0);
    check("ovr slave_ready", srdy2, 0);
    idx = 4;
    for (int c = 0; c < 40 && rx.size() < 6; c++) begin
      sv2 = (idx < 6); sd2 = 64'h40 + 64'(idx); sl2 = (idx == 5); mr2 = 1'b1;
      #1;
      if (lvl2 == 3'd4) check("ovr valid when full", mv2, 1);
      do_push = sv2 & srdy2;
      do_pop  = mv2 & mr2;
      if (do_pop) rx.push_back(md2);
      tick();
      if (do_push) idx++;
    end
    sv2 = 1'b0; mr2 = 1'b0;
    check("ovr beats delivered (deadlock)", 64'(rx.size()), 6);
    for (int i = 0; i < rx.size(); i++) begin
      check($sformatf("ovr order %0d", i), rx[i], 64'h40 + 64'(i));
    end
    #1;
    check("ovr end level", lvl2, 0);
    check("ovr end bursts", bur2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
